// File: rtl/lfsr_stream.sv
// LFSR word generator with a valid/ready output stream.
// Burst-oriented: load a seed, request N words, receive a done pulse.
module lfsr_stream #(
   parameter int unsigned      WIDTH        = 8,
   parameter logic [WIDTH-1:0] TAPS         = 8'h1D,
   parameter bit               GALOIS       = 1'b0,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01,
   parameter int unsigned      CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seed_valid,
   input  logic [WIDTH-1:0] seed,
   output logic             seed_ready,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output logic             zero_seed
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] anchor;
   logic [WIDTH-1:0] next_lfsr;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] start_val;
   logic [CNT_W-1:0] remaining;
   logic             seed_acc;
   logic             seed_zero;

   generate
      if (GALOIS) begin : g_galois
         assign next_lfsr = {1'b0, lfsr[WIDTH-1:1]}
                          ^ ({WIDTH{lfsr[0]}} & TAPS);
      end else begin : g_fib
         assign next_lfsr = {^(lfsr & TAPS), lfsr[WIDTH-1:1]};
      end
   endgenerate

   // A same-cycle seed load wins over the current state as burst origin.
   assign seed_zero = (seed == '0);
   assign seed_acc  = seed_valid && (state == IDLE);
   assign load_val  = seed_zero ? DEFAULT_SEED : seed;
   assign start_val = seed_acc ? load_val : lfsr;
   assign out_data  = lfsr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         lfsr       <= DEFAULT_SEED;
         anchor     <= DEFAULT_SEED;
         remaining  <= '0;
         out_valid  <= 1'b0;
         done       <= 1'b0;
         wrap       <= 1'b0;
         zero_seed  <= 1'b0;
         busy       <= 1'b0;
         seed_ready <= 1'b1;
      end else begin
         done <= 1'b0;
         wrap <= 1'b0;
         unique case (state)
            IDLE: begin
               if (seed_acc) begin
                  lfsr <= load_val;
                  if (seed_zero) zero_seed <= 1'b1;
               end
               if (start) begin
                  if (count != '0) begin
                     remaining  <= count;
                     anchor     <= start_val;
                     state      <= RUN;
                     out_valid  <= 1'b1;
                     busy       <= 1'b1;
                     seed_ready <= 1'b0;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (out_ready) begin
                  lfsr      <= next_lfsr;
                  remaining <= remaining - 1'b1;
                  wrap      <= (next_lfsr == anchor);
                  if (remaining == CNT_W'(1)) begin
                     state     <= DONE;
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               busy       <= 1'b0;
               seed_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: Fibonacci and Galois instances share stimulus
// and are checked against an arithmetic reference model.
module tb_lfsr_stream;

   logic        clk = 1'b0;
   logic        reset;
   logic        seed_valid;
   logic [7:0]  seed;
   logic        start;
   logic [15:0] count;
   logic        out_ready;

   logic       f_seed_ready, f_out_valid, f_busy, f_done, f_wrap, f_zero;
   logic [7:0] f_data;
   logic       g_seed_ready, g_out_valid, g_busy, g_done, g_wrap, g_zero;
   logic [7:0] g_data;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] mf, mg;
   bit         mzero;
   int         wraps_f, wraps_g, reps_f, reps_g, zeros;
   logic [7:0] obs_f[$];
   logic [7:0] obs_g[$];
   bit         seen_f[logic [7:0]];
   bit         seen_g[logic [7:0]];
   bit         rq[$];

   always #5 clk = ~clk;

   lfsr_stream dut_f (
      .clk(clk), .reset(reset),
      .seed_valid(seed_valid), .seed(seed), .seed_ready(f_seed_ready),
      .start(start), .count(count),
      .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_data),
      .busy(f_busy), .done(f_done), .wrap(f_wrap), .zero_seed(f_zero)
   );

   lfsr_stream #(
      .WIDTH(8), .TAPS(8'hB8), .GALOIS(1'b1),
      .DEFAULT_SEED(8'h01), .CNT_W(16)
   ) dut_g (
      .clk(clk), .reset(reset),
      .seed_valid(seed_valid), .seed(seed), .seed_ready(g_seed_ready),
      .start(start), .count(count),
      .out_valid(g_out_valid), .out_ready(out_ready), .out_data(g_data),
      .busy(g_busy), .done(g_done), .wrap(g_wrap), .zero_seed(g_zero)
   );

   // Reference: Fibonacci = shift right with parity of tapped bits on top;
   // Galois = shift right, XOR taps in when the dropped bit was 1.
   function automatic logic [7:0] m_next(input logic [7:0] x,
                                         input bit gal,
                                         input logic [7:0] taps);
      int ones;
      if (gal) return (x >> 1) ^ ((x % 2 == 1) ? taps : 8'h00);
      ones = $countones(x & taps);
      return (x >> 1) + ((ones % 2 == 1) ? 8'd128 : 8'd0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mf = 8'h01;
      mg = 8'h01;
      mzero = 1'b0;
   endtask

   task automatic load_seed(input logic [7:0] sd);
      seed_valid = 1'b1;
      seed = sd;
      tick();
      seed_valid = 1'b0;
      if (sd == 8'h00) begin
         mf = 8'h01; mg = 8'h01; mzero = 1'b1;
      end else begin
         mf = sd; mg = sd;
      end
      chk("load_data_f", 32'(f_data), 32'(mf));
      chk("load_data_g", 32'(g_data), 32'(mg));
      chk("load_zero", 32'(f_zero), 32'(mzero));
      chk("load_valid", 32'(f_out_valid), 0);
   endtask

   task automatic burst(input bit use_seed, input logic [7:0] sd,
                        input int cnt, input int pct);
      logic [7:0] af, ag, nf, ng;
      bit wf, wg, rdy;
      int hs, cyc;
      obs_f.delete(); obs_g.delete();
      seen_f.delete(); seen_g.delete();
      wraps_f = 0; wraps_g = 0; reps_f = 0; reps_g = 0; zeros = 0;
      seed_valid = use_seed;
      seed = sd;
      start = 1'b1;
      count = 16'(cnt);
      out_ready = 1'b0;
      tick();
      if (use_seed) begin
         if (sd == 8'h00) begin
            mf = 8'h01; mg = 8'h01; mzero = 1'b1;
         end else begin
            mf = sd; mg = sd;
         end
      end
      seed_valid = 1'b0;
      start = 1'b0;
      af = mf; ag = mg; wf = 1'b0; wg = 1'b0; hs = 0; cyc = 0;
      if (cnt == 0) begin
         chk("zc_done", 32'(f_done), 1);
         chk("zc_valid", 32'(f_out_valid), 0);
         chk("zc_busy", 32'(f_busy), 0);
         tick();
         chk("zc_done_off", 32'(f_done), 0);
         chk("zc_valid2", 32'(f_out_valid), 0);
         return;
      end
      while (hs < cnt && cyc < 30 * cnt + 50) begin
         chk("valid", 32'(f_out_valid), 1);
         chk("valid_g", 32'(g_out_valid), 1);
         chk("busy", 32'(f_busy), 1);
         chk("seed_rdy", 32'(f_seed_ready), 0);
         chk("done", 32'(f_done), 0);
         chk("data_f", 32'(f_data), 32'(mf));
         chk("data_g", 32'(g_data), 32'(mg));
         chk("wrap_f", 32'(f_wrap), 32'(wf));
         chk("wrap_g", 32'(g_wrap), 32'(wg));
         chk("zero_flag", 32'(f_zero), 32'(mzero));
         if (f_wrap) wraps_f++;
         if (g_wrap) wraps_g++;
         if (rq.size() > 0) rdy = rq.pop_front();
         else rdy = ($urandom_range(0, 99) < pct);
         if (rdy) begin
            if (seen_f.exists(f_data)) reps_f++;
            if (seen_g.exists(g_data)) reps_g++;
            if (f_data == 8'h00 || g_data == 8'h00) zeros++;
            seen_f[f_data] = 1'b1;
            seen_g[g_data] = 1'b1;
            obs_f.push_back(f_data);
            obs_g.push_back(g_data);
         end
         // Junk on the control inputs must be ignored while running.
         seed_valid = 1'($urandom_range(0, 1));
         seed = 8'($urandom);
         start = 1'($urandom_range(0, 1));
         count = 16'($urandom);
         out_ready = rdy;
         tick();
         cyc++;
         if (rdy) begin
            nf = m_next(mf, 1'b0, 8'h1D);
            ng = m_next(mg, 1'b1, 8'hB8);
            wf = (nf == af);
            wg = (ng == ag);
            mf = nf; mg = ng;
            hs++;
         end else begin
            wf = 1'b0; wg = 1'b0;
         end
      end
      seed_valid = 1'b0;
      start = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      if (hs < cnt) chk("timeout", 32'(hs), 32'(cnt));
      chk("end_done", 32'(f_done), 1);
      chk("end_done_g", 32'(g_done), 1);
      chk("end_valid", 32'(f_out_valid), 0);
      chk("end_busy", 32'(f_busy), 1);
      chk("end_data_f", 32'(f_data), 32'(mf));
      chk("end_data_g", 32'(g_data), 32'(mg));
      chk("end_wrap_f", 32'(f_wrap), 32'(wf));
      chk("end_wrap_g", 32'(g_wrap), 32'(wg));
      if (f_wrap) wraps_f++;
      if (g_wrap) wraps_g++;
      tick();
      chk("idle_done", 32'(f_done), 0);
      chk("idle_busy", 32'(f_busy), 0);
      chk("idle_seed_rdy", 32'(f_seed_ready), 1);
      chk("idle_valid", 32'(f_out_valid), 0);
      chk("idle_data", 32'(f_data), 32'(mf));
   endtask

   logic [7:0] exp_fib[6] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
   logic [7:0] exp_gal[5] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};

   initial begin
      seed_valid = 1'b0;
      seed = 8'h00;
      start = 1'b0;
      count = 16'h0;
      out_ready = 1'b0;
      reset = 1'b1;
      tick();
      do_reset();
      chk("rst_valid", 32'(f_out_valid), 0);
      chk("rst_done", 32'(f_done), 0);
      chk("rst_wrap", 32'(f_wrap), 0);
      chk("rst_zero", 32'(f_zero), 0);
      chk("rst_busy", 32'(f_busy), 0);
      chk("rst_seed_rdy", 32'(f_seed_ready), 1);
      chk("rst_data_f", 32'(f_data), 32'h01);
      chk("rst_data_g", 32'(g_data), 32'h01);

      // Seed and start together, six words at full rate.
      burst(1'b1, 8'h01, 6, 100);
      chk("b6_len", 32'(obs_f.size()), 6);
      for (int i = 0; i < 6 && i < obs_f.size(); i++)
         chk($sformatf("b6_word%0d", i), 32'(obs_f[i]), 32'(exp_fib[i]));

      // Zero seed substitution, then a stalled burst from 0x01.
      load_seed(8'h00);
      chk("zs_data", 32'(f_data), 32'h01);
      chk("zs_flag_g", 32'(g_zero), 1);
      rq = '{1, 0, 0, 1, 1, 0, 1};
      burst(1'b0, 8'h00, 4, 100);
      chk("stall_len", 32'(obs_f.size()), 4);
      for (int i = 0; i < 4 && i < obs_f.size(); i++)
         chk($sformatf("stall_word%0d", i), 32'(obs_f[i]), 32'(exp_fib[i]));
      chk("zs_sticky", 32'(f_zero), 1);

      // Full period for both structures.
      burst(1'b1, 8'h01, 255, 100);
      chk("p255_len", 32'(obs_f.size()), 255);
      chk("p255_reps_f", 32'(reps_f), 0);
      chk("p255_reps_g", 32'(reps_g), 0);
      chk("p255_zeros", 32'(zeros), 0);
      chk("p255_wraps_f", 32'(wraps_f), 1);
      chk("p255_wraps_g", 32'(wraps_g), 1);
      for (int i = 0; i < 5 && i < obs_g.size(); i++)
         chk($sformatf("gal_word%0d", i), 32'(obs_g[i]), 32'(exp_gal[i]));

      // Random bursts with random seeds and backpressure.
      for (int k = 0; k < 8; k++) begin
         logic [7:0] sd;
         sd = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
         burst(1'($urandom_range(0, 1)), sd,
               $urandom_range(1, 40), $urandom_range(30, 100));
      end

      // Reset in the middle of a burst.
      seed_valid = 1'b1;
      seed = 8'h5A;
      start = 1'b1;
      count = 16'd10;
      out_ready = 1'b1;
      tick();
      seed_valid = 1'b0;
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("mid_busy", 32'(f_busy), 1);
      do_reset();
      chk("mid_valid", 32'(f_out_valid), 0);
      chk("mid_data", 32'(f_data), 32'h01);
      chk("mid_done", 32'(f_done), 0);
      chk("mid_busy_off", 32'(f_busy), 0);
      chk("mid_seed_rdy", 32'(f_seed_ready), 1);
      chk("mid_zero", 32'(f_zero), 0);
      out_ready = 1'b0;
      tick();
      chk("mid_done2", 32'(f_done), 0);
      chk("mid_valid2", 32'(f_out_valid), 0);

      burst(1'b0, 8'h00, 0, 100);
      chk("zc_data", 32'(f_data), 32'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lfsr_stream.md
Name: lfsr_stream

Overview:
- Parametrised LFSR pseudo-random word generator with a valid/ready output stream.
- Software or a test driver loads a seed, then requests a burst of N words. The block emits one word per accepted handshake, then pulses done.
- Supports Fibonacci or Galois structure, arbitrary width and tap mask, zero-seed protection, and a period-wrap indicator.
- Used as a stimulus and scrambler source feeding downstream consumers that may stall.

Parameters:
- WIDTH, 8, state and output word width (>=3).
- TAPS, 8'h1D, tap mask. Fibonacci: feedback = XOR of state bits where the mask bit is 1. Galois: XOR mask applied when the shifted-out bit is 1.
- GALOIS, 0, 0 = Fibonacci shift-right, 1 = Galois shift-right.
- DEFAULT_SEED, 8'h01, value loaded at reset and substituted for a zero seed (must be nonzero).
- CNT_W, 16, width of the burst length counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- seed_valid  in  1  seed offered
- seed  in  WIDTH  seed value
- seed_ready  out  1  seed accepted this cycle when seed_valid && seed_ready
- start  in  1  begin burst (sampled in IDLE only)
- count  in  CNT_W  burst length, sampled with start
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- out_data  out  WIDTH  current LFSR state
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse at end of burst
- wrap  out  1  one-cycle pulse when the state returns to the burst's first word
- zero_seed  out  1  sticky: a zero seed was substituted

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high: on posedge clk with reset=1, the block applies reset state regardless of other inputs, mid-burst included.
- Reset state:
  - state=IDLE, lfsr=DEFAULT_SEED, remaining=0, anchor=DEFAULT_SEED.
  - out_valid=0, done=0, wrap=0, zero_seed=0, busy=0, seed_ready=1.
  - out_data=DEFAULT_SEED.
- Next-state function:
  - Fibonacci: fb = ^(lfsr & TAPS); next = {fb, lfsr[WIDTH-1:1]}.
  - Galois: next = {1'b0, lfsr[WIDTH-1:1]} ^ ({WIDTH{lfsr[0]}} & TAPS).
- out_data = lfsr at all times (registered, no combinational path from inputs).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - seed_ready=1, out_valid=0.
  - Seed accept: lfsr <= (seed==0 ? DEFAULT_SEED : seed). A zero seed also sets zero_seed (sticky until reset).
  - start=1 with count!=0: remaining <= count, anchor <= lfsr value after any same-cycle seed load, go to RUN.
  - Seed and start in the same cycle: the seed is loaded first, and the burst starts from the new seed.
  - start=1 with count==0: no words emitted, done pulses next cycle, stay IDLE (busy stays 0).
- RUN:
  - seed_ready=0, out_valid=1, busy=1. seed_valid and start are ignored.
  - On out_valid && out_ready: lfsr <= next, remaining <= remaining-1.
  - If next == anchor, wrap pulses in the following cycle.
  - If remaining==1 at acceptance, go to DONE.
  - With out_ready=0, out_data and out_valid stay stable indefinitely (AXI-style; valid never drops without a handshake).
- DONE: out_valid=0, done=1 for exactly one cycle, then return to IDLE. The lfsr retains its last advanced value, so a subsequent start continues the sequence.
- Latency:
  - The first word is valid on the cycle after the start edge.
  - With out_ready held high, one word per cycle.
  - done is asserted the cycle after the final handshake.
- The counter is CNT_W bits wide. count=2^CNT_W-1 is the maximum burst, with no wrap of remaining.
- Default Fibonacci configuration (x^8+x^4+x^3+x^2+1) is maximal: period 255, never reaches 0.

Test Plan:
- Reset, then seed=0x01, start count=6, out_ready=1 -> out_data 01,80,40,20,10,88 on consecutive cycles; done pulse one cycle after 0x88 accepted; busy low afterwards.
- seed=0x00 load -> lfsr=0x01, zero_seed=1 and stays 1 until reset; next burst starts at 0x01.
- Burst count=4 with out_ready toggling 1,0,0,1,1,0,1 -> exactly 4 handshakes, out_data constant during stalls, values 01,80,40,20.
- count=255 from seed 0x01, out_ready=1 -> 255 distinct nonzero words; wrap pulses exactly once, after the 255th handshake; done then pulses.
- Reset asserted mid-burst (after 3 words) -> next cycle out_valid=0, state IDLE, out_data=0x01, no done pulse; start count=0 in IDLE -> single done pulse, no out_valid.
- GALOIS=1, TAPS=8'hB8, seed 0x01 -> 0x01,0xB8,0x5C,0x2E,0x17; full run of 255 words has no repeats.
